// File: rtl/mixed_four_or_if.sv
// Operand/result bundle for mixed_four_or: master drives a..d, slave returns f, f_q and edge flags.
// act_cnt and its CNT_W parameter exist only when MIXED_FOUR_OR_ACT_CNT_EN is defined.
interface mixed_four_or_if #(
  parameter int WIDTH = 1
`ifdef MIXED_FOUR_OR_ACT_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_q;
  logic             any_q;
  logic             rise;
  logic             fall;
`ifdef MIXED_FOUR_OR_ACT_CNT_EN
  logic [CNT_W-1:0] act_cnt;
`endif

  modport master (
    output a, b, c, d,
    input  f, f_q, any_q, rise, fall
`ifdef MIXED_FOUR_OR_ACT_CNT_EN
    , input act_cnt
`endif
  );

  modport slave (
    input  a, b, c, d,
    output f, f_q, any_q, rise, fall
`ifdef MIXED_FOUR_OR_ACT_CNT_EN
    , output act_cnt
`endif
  );
endinterface

// File: rtl/mixed_four_or.sv
// Four-input OR (gate, dataflow, behavioural stages); f is zero-latency, f_q/any_q/rise/fall lag one clk, no backpressure.
// Optional saturating activity counter on act_cnt when MIXED_FOUR_OR_ACT_CNT_EN is defined.
module mixed_four_or #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  mixed_four_or_if.slave io
);
  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] cd;
  logic [WIDTH-1:0] f_comb;
  logic [WIDTH-1:0] f_q_r;
  logic             any_q;
  logic             prev_any;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ab
    or u_or (ab[i], io.a[i], io.b[i]);
  end

  assign cd = io.c | io.d;

  always_comb begin
    f_comb = ab | cd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q_r    <= '0;
      prev_any <= 1'b0;
    end else begin
      f_q_r    <= f_comb;
      prev_any <= any_q;
    end
  end

  assign any_q    = |f_q_r;
  assign io.f     = f_comb;
  assign io.f_q   = f_q_r;
  assign io.any_q = any_q;
  // prev_any and any_q can never both be the opposite values, so rise and fall are exclusive.
  assign io.rise  = any_q & ~prev_any;
  assign io.fall  = ~any_q & prev_any;

`ifdef MIXED_FOUR_OR_ACT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] act_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt_r <= '0;
    end else if (any_q && (act_cnt_r != '1)) begin
      act_cnt_r <= act_cnt_r + CNT_ONE;
    end
  end

  assign io.act_cnt = act_cnt_r;
`else
  // No counter in this build; CNT_W stays in the parameter list so both builds instantiate alike.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif
endmodule

// File: tb/tb_mixed_four_or.sv
// Scoreboard bench for mixed_four_or: WIDTH=1 instance (CNT_W=3) plus a WIDTH=4 instance.
module tb_mixed_four_or;
  localparam int CW = 3;

  typedef struct packed {
    logic          f;
    logic          fq;
    logic          any;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef MIXED_FOUR_OR_ACT_CNT_EN
  mixed_four_or_if #(.WIDTH(1), .CNT_W(CW)) bus ();
`else
  mixed_four_or_if #(.WIDTH(1)) bus ();
`endif
  mixed_four_or_if #(.WIDTH(4)) bus_w ();

  mixed_four_or #(.WIDTH(1), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .io(bus));
  mixed_four_or #(.WIDTH(4), .CNT_W(16)) dut_w (.clk(clk), .rst(rst), .io(bus_w));

  exp_t          sb[$];
  logic [3:0]    wq[$];
  logic          m_fq  = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  // Drive one cycle of stimulus and queue what the cell must show now (f) and after the edge.
  task automatic apply(input logic [3:0] abcd, input logic r);
    exp_t e;
    logic prev_n;
    {bus.a, bus.b, bus.c, bus.d} = abcd;
    rst    = r;
    e.f    = |abcd;
    e.fq   = r ? 1'b0 : e.f;
    e.any  = e.fq;
    prev_n = r ? 1'b0 : m_fq;
    e.rise = e.any & ~prev_n;
    e.fall = ~e.any & prev_n;
    e.cnt  = r ? '0 : ((m_fq && m_cnt != {CW{1'b1}}) ? m_cnt + CW'(1) : m_cnt);
    m_fq   = e.fq;
    m_cnt  = e.cnt;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      apply(4'b1111, (i < 2));
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.f !== e.f) begin
        n_bad++; $display("FAIL reset[%0d] f: got %b want %b", i, bus.f, e.f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.f_q, bus.any_q, bus.rise, bus.fall} !== {e.fq, e.any, e.rise, e.fall}) begin
        n_bad++;
        $display("FAIL reset[%0d] fq/any/rise/fall: got %b want %b", i,
                 {bus.f_q, bus.any_q, bus.rise, bus.fall}, {e.fq, e.any, e.rise, e.fall});
      end
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    logic [3:0] seq [7];
    logic       rs  [7];
    seq = '{4'b0000, 4'b0000, 4'b1111, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
    rs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      apply(seq[i], rs[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.f !== e.f) begin
        n_bad++; $display("FAIL seq[%0d] f: got %b want %b", i, bus.f, e.f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.f_q, bus.any_q, bus.rise, bus.fall} !== {e.fq, e.any, e.rise, e.fall}) begin
        n_bad++;
        $display("FAIL seq[%0d] fq/any/rise/fall: got %b want %b", i,
                 {bus.f_q, bus.any_q, bus.rise, bus.fall}, {e.fq, e.any, e.rise, e.fall});
      end
    end
  endtask

  task automatic test_single_hot();
    exp_t e;
    logic [3:0] v;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? (4'b1000 >> (i / 2)) : 4'b0000;
      apply(v, 1'b0);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.f !== e.f) begin
        n_bad++; $display("FAIL hot[%0d] f: got %b want %b", i, bus.f, e.f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.f_q, bus.any_q, bus.rise, bus.fall} !== {e.fq, e.any, e.rise, e.fall}) begin
        n_bad++;
        $display("FAIL hot[%0d] fq/any/rise/fall: got %b want %b", i,
                 {bus.f_q, bus.any_q, bus.rise, bus.fall}, {e.fq, e.any, e.rise, e.fall});
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [3:0] seq [5];
    logic       rs  [5];
    seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    rs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(seq[i], rs[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.f !== e.f) begin
        n_bad++; $display("FAIL midrst[%0d] f: got %b want %b", i, bus.f, e.f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.f_q, bus.any_q, bus.rise, bus.fall} !== {e.fq, e.any, e.rise, e.fall}) begin
        n_bad++;
        $display("FAIL midrst[%0d] fq/any/rise/fall: got %b want %b", i,
                 {bus.f_q, bus.any_q, bus.rise, bus.fall}, {e.fq, e.any, e.rise, e.fall});
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    logic [3:0] fe;
    logic [15:0] vec [3];
    vec = '{16'b0001_0010_0100_0000, 16'b1000_0000_0000_0000, 16'b0000_0000_0000_0000};
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, 1'b0);
      {bus_w.a, bus_w.b, bus_w.c, bus_w.d} = vec[i];
      wq.push_back(vec[i][15:12] | vec[i][11:8] | vec[i][7:4] | vec[i][3:0]);
      #1;
      e  = sb.pop_front();
      fe = wq[0];
      n_cmp++;
      if (bus_w.f !== fe) begin
        n_bad++; $display("FAIL wide[%0d] f: got %b want %b", i, bus_w.f, fe);
      end
      @(posedge clk); #1;
      fe = wq.pop_front();
      n_cmp++;
      if ({bus_w.f_q, bus_w.any_q} !== {fe, |fe}) begin
        n_bad++; $display("FAIL wide[%0d] fq/any: got %b want %b", i, {bus_w.f_q, bus_w.any_q}, {fe, |fe});
      end
      n_cmp++;
      if ({bus.f_q, bus.rise, bus.fall} !== {e.fq, e.rise, e.fall}) begin
        n_bad++; $display("FAIL wide[%0d] narrow fq/rise/fall: got %b want %b", i,
                          {bus.f_q, bus.rise, bus.fall}, {e.fq, e.rise, e.fall});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] v;
    logic       r;
    for (int i = 0; i < 24; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 7) == 0);
      apply(v, r);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.f !== e.f) begin
        n_bad++; $display("FAIL b2b[%0d] f: got %b want %b", i, bus.f, e.f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.f_q, bus.any_q, bus.rise, bus.fall} !== {e.fq, e.any, e.rise, e.fall}) begin
        n_bad++;
        $display("FAIL b2b[%0d] fq/any/rise/fall: got %b want %b", i,
                 {bus.f_q, bus.any_q, bus.rise, bus.fall}, {e.fq, e.any, e.rise, e.fall});
      end
    end
  endtask

`ifdef MIXED_FOUR_OR_ACT_CNT_EN
  task automatic test_act_cnt();
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      apply(4'b1111, (i == 0 || i == 12));
      #1;
      e = sb.pop_front();
      @(posedge clk); #1;
      n_cmp++;
      if (bus.act_cnt !== e.cnt) begin
        n_bad++; $display("FAIL act_cnt[%0d]: got %0d want %0d", i, bus.act_cnt, e.cnt);
      end
      n_cmp++;
      if ({bus.f_q, bus.rise, bus.fall} !== {e.fq, e.rise, e.fall}) begin
        n_bad++; $display("FAIL act_cnt[%0d] fq/rise/fall: got %b want %b", i,
                          {bus.f_q, bus.rise, bus.fall}, {e.fq, e.rise, e.fall});
      end
    end
  endtask
`endif

  initial begin
    {bus.a, bus.b, bus.c, bus.d} = 4'b0000;
    {bus_w.a, bus_w.b, bus_w.c, bus_w.d} = 16'h0000;
    test_reset();
    test_sequence();
    test_single_hot();
    test_mid_reset();
    test_wide();
    test_back_to_back();
`ifdef MIXED_FOUR_OR_ACT_CNT_EN
    test_act_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
